// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video pattern generator: mode encodings,
// colour-bar table and checkerboard square size.
package video_timing_pkg;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_GRAD   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    // Checkerboard squares are 2**CHECK_SHIFT pixels wide.
    localparam int unsigned CHECK_SHIFT = 4;

    // {R,G,B}, one bit per channel; white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with active, sync and frame-end decode.
module video_timing_counter
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          pixel_clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] hc_o,
    output logic [VW-1:0] vc_o,
    output logic          active_o,
    output logic          hsync_act_o,
    output logic          vsync_act_o,
    output logic          frame_end_o
);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          h_last, v_last;

    assign h_last = (hc_q == HW'(H_TOTAL - 1));
    assign v_last = (vc_q == VW'(V_TOTAL - 1));

    always_comb begin
        hc_d = hc_q + HW'(1);
        vc_d = vc_q;
        if (h_last) begin
            hc_d = '0;
            vc_d = v_last ? '0 : vc_q + VW'(1);
        end
    end

    always_ff @(posedge pixel_clk_i) begin
        if (rst_i) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc_o        = hc_q;
    assign vc_o        = vc_q;
    assign active_o    = (hc_q < HW'(H_ACTIVE)) && (vc_q < VW'(V_ACTIVE));
    assign hsync_act_o = (hc_q >= HW'(H_ACTIVE + H_FP)) && (hc_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_act_o = (vc_q >= VW'(V_ACTIVE + V_FP)) && (vc_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/video_pattern_generator.sv
// Parametrised video timing and test-pattern source with registered outputs.
// Define VPG_BORDER_EN to force a one-pixel white border around the active area.
module video_pattern_generator
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned COLOR_BITS = 8,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW        = $clog2(H_TOTAL),
    localparam int unsigned VW        = $clog2(V_TOTAL)
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic [3:0]            ctl,
    output logic [COLOR_BITS-1:0] pixel_data_0,
    output logic [COLOR_BITS-1:0] pixel_data_1,
    output logic [COLOR_BITS-1:0] pixel_data_2,
    output logic [HW-1:0]         x,
    output logic [VW-1:0]         y,
    output logic                  frame_start
);

    localparam int unsigned BarW = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int unsigned YW   = (COLOR_BITS > CHECK_SHIFT + 1) ? COLOR_BITS : CHECK_SHIFT + 1;

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          active, hsync_act, vsync_act, frame_end;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .pixel_clk_i (pixel_clk),
        .rst_i       (rst),
        .hc_o        (hc),
        .vc_o        (vc),
        .active_o    (active),
        .hsync_act_o (hsync_act),
        .vsync_act_o (vsync_act),
        .frame_end_o (frame_end)
    );

    mode_e                 mode_q;
    logic [7:0]            frame_cnt_q;
    logic                  de_q, hsync_q, vsync_q, frame_start_q;
    logic [HW-1:0]         x_q;
    logic [VW-1:0]         y_q;
    logic [COLOR_BITS-1:0] blue_q, green_q, red_q;
    logic [COLOR_BITS-1:0] blue_d, green_d, red_d;

    logic [31:0]   hx, scroll_sum;
    logic [YW-1:0] vy;
    logic [2:0]    bar_idx, bar_rgb;

    assign hx         = 32'(hc);
    assign vy         = YW'(vc);
    assign scroll_sum = hx + {24'd0, frame_cnt_q};
    assign bar_idx    = (hx >= 8 * BarW) ? 3'd7 : 3'(hx / BarW);
    assign bar_rgb    = BAR_RGB[bar_idx];

    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (active) begin
            unique case (mode_q)
                MODE_BARS: begin
                    red_d   = {COLOR_BITS{bar_rgb[2]}};
                    green_d = {COLOR_BITS{bar_rgb[1]}};
                    blue_d  = {COLOR_BITS{bar_rgb[0]}};
                end
                MODE_GRAD: begin
                    red_d   = hx[COLOR_BITS-1:0];
                    green_d = hx[COLOR_BITS-1:0];
                    blue_d  = hx[COLOR_BITS-1:0];
                end
                MODE_CHECK: begin
                    red_d   = {COLOR_BITS{hx[CHECK_SHIFT] ^ vy[CHECK_SHIFT]}};
                    green_d = red_d;
                    blue_d  = red_d;
                end
                MODE_SCROLL: begin
                    red_d   = scroll_sum[COLOR_BITS-1:0];
                    green_d = vy[COLOR_BITS-1:0];
                    blue_d  = COLOR_BITS'(frame_cnt_q);
                end
            endcase
`ifdef VPG_BORDER_EN
            if (hx == 32'd0 || hx == H_ACTIVE - 1 || 32'(vc) == 32'd0 ||
                32'(vc) == V_ACTIVE - 1) begin
                red_d   = '1;
                green_d = '1;
                blue_d  = '1;
            end
`endif
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            mode_q        <= MODE_BARS;
            frame_cnt_q   <= '0;
            de_q          <= 1'b0;
            hsync_q       <= !HSYNC_POL;
            vsync_q       <= !VSYNC_POL;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            // New mode and frame count apply from the first pixel of the next frame.
            if (frame_end) begin
                mode_q      <= mode_e'(mode);
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            de_q          <= active;
            hsync_q       <= hsync_act ? HSYNC_POL : !HSYNC_POL;
            vsync_q       <= vsync_act ? VSYNC_POL : !VSYNC_POL;
            frame_start_q <= (hc == '0) && (vc == '0);
            x_q           <= hc;
            y_q           <= vc;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign de           = de_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign ctl          = 4'b0000;
    assign pixel_data_0 = blue_q;
    assign pixel_data_1 = green_q;
    assign pixel_data_2 = red_q;
    assign x            = x_q;
    assign y            = y_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_video_pattern_generator.sv
// Directed bench: small raster (A), 16-wide bars raster (B), 32x32 raster for mode latching (C).
module tb_video_pattern_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0, mode_c = 2'd0;
    int total = 0;
    int bad   = 0;
    int cur   = 0;

    always #5 clk = ~clk;

    // A: H 8/2/3/3 (16), V 4/1/2/1 (8)
    logic de_a, hs_a, vs_a, fs_a;
    logic [3:0] ctl_a;
    logic [7:0] b_a, g_a, r_a;
    logic [3:0] x_a;
    logic [2:0] y_a;
    video_pattern_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_a (
        .pixel_clk(clk), .rst(rst), .mode(mode_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
        .ctl(ctl_a), .pixel_data_0(b_a), .pixel_data_1(g_a), .pixel_data_2(r_a),
        .x(x_a), .y(y_a), .frame_start(fs_a)
    );

    // B: H 16/2/3/3 (24), V 4/1/2/1 (8)
    logic de_b, hs_b, vs_b, fs_b;
    logic [3:0] ctl_b;
    logic [7:0] b_b, g_b, r_b;
    logic [4:0] x_b;
    logic [2:0] y_b;
    video_pattern_generator #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .pixel_clk(clk), .rst(rst), .mode(mode_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
        .ctl(ctl_b), .pixel_data_0(b_b), .pixel_data_1(g_b), .pixel_data_2(r_b),
        .x(x_b), .y(y_b), .frame_start(fs_b)
    );

    // C: H 32/2/3/3 (40), V 32/1/2/1 (36), frame = 1440 cycles
    logic de_c, hs_c, vs_c, fs_c;
    logic [3:0] ctl_c;
    logic [7:0] b_c, g_c, r_c;
    logic [5:0] x_c;
    logic [5:0] y_c;
    video_pattern_generator #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_c (
        .pixel_clk(clk), .rst(rst), .mode(mode_c), .de(de_c), .hsync(hs_c), .vsync(vs_c),
        .ctl(ctl_c), .pixel_data_0(b_c), .pixel_data_1(g_c), .pixel_data_2(r_c),
        .x(x_c), .y(y_c), .frame_start(fs_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cur++;
    endtask

    // Advance until sample index n (sample 0 shows raster position 0 after reset release).
    task automatic goto(input int n);
        while (cur < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        cur = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({de_a, hs_a, vs_a, fs_a, ctl_a, x_a, y_a} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 3'h0}) begin
            bad++;
            $display("FAIL reset_ctrl got de=%b hs=%b vs=%b fs=%b ctl=%h x=%0d y=%0d", de_a, hs_a,
                     vs_a, fs_a, ctl_a, x_a, y_a);
        end
        total++;
        if ({r_a, g_a, b_a} !== 24'h000000) begin
            bad++;
            $display("FAIL reset_pixel got %h want 000000", {r_a, g_a, b_a});
        end
        rst = 1'b0;
        step();
        cur = 0;
        total++;
        if ({x_a, y_a, de_a, fs_a} !== {4'd0, 3'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL first_pixel got x=%0d y=%0d de=%b fs=%b want 0 0 1 1", x_a, y_a, de_a, fs_a);
        end
        total++;
        if ({r_a, g_a, b_a} !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL first_pixel_white got %h want ffffff", {r_a, g_a, b_a});
        end
    endtask

    task automatic test_timing();
        int hc, vc;
        logic [10:0] got, exp;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            goto(n);
            hc  = n % 16;
            vc  = (n / 16) % 8;
            exp = {(hc < 8) && (vc < 4), !(hc >= 10 && hc <= 12), !(vc >= 5 && vc <= 6),
                   (hc == 0) && (vc == 0), 4'(hc), 3'(vc)};
            got = {de_a, hs_a, vs_a, fs_a, x_a, y_a};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL timing n=%0d got de/hs/vs/fs/x/y=%b want %b", n, got, exp);
            end
        end
    endtask

    task automatic test_bars();
        logic [23:0] bars [8];
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        mode_b = 2'd0;
        do_reset();
        for (int n = 0; n < 16; n++) begin
            goto(n);
            total++;
            if ({r_b, g_b, b_b} !== bars[n / 2]) begin
                bad++;
                $display("FAIL bars x=%0d got %h want %h", n, {r_b, g_b, b_b}, bars[n / 2]);
            end
        end
        goto(20);
        total++;
        if ({r_b, g_b, b_b, de_b} !== 25'd0) begin
            bad++;
            $display("FAIL blank_black got rgb=%h de=%b want 000000 0", {r_b, g_b, b_b}, de_b);
        end
    endtask

    task automatic test_mode_latch();
        int pts [4];
        logic [23:0] exp [4];
        pts = '{16, 656, 1440 + 16, 1440 + 656};
        exp = '{24'hFF00FF, 24'hFF00FF, 24'hFFFFFF, 24'h000000};
        mode_c = 2'd0;
        do_reset();
        goto(5);
        mode_c = 2'd2;
        for (int i = 0; i < 4; i++) begin
            goto(pts[i]);
            total++;
            if ({r_c, g_c, b_c} !== exp[i]) begin
                bad++;
                $display("FAIL mode_latch x=%0d y=%0d got %h want %h", x_c, y_c, {r_c, g_c, b_c},
                         exp[i]);
            end
        end
    endtask

    task automatic test_scroll();
        int fr [5];
        logic [7:0] eb [5];
        logic [7:0] er [5];
        fr = '{1, 2, 3, 255, 256};
        eb = '{8'd1, 8'd2, 8'd3, 8'd255, 8'd0};
        er = '{8'd6, 8'd7, 8'd8, 8'd4, 8'd5};
        mode_a = 2'd3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            goto(fr[i] * 128);
            total++;
            if (b_a !== eb[i]) begin
                bad++;
                $display("FAIL scroll_blue frame=%0d got %h want %h", fr[i], b_a, eb[i]);
            end
            goto(fr[i] * 128 + 5);
            total++;
            if (r_a !== er[i]) begin
                bad++;
                $display("FAIL scroll_red frame=%0d got %h want %h", fr[i], r_a, er[i]);
            end
        end
        goto(256 * 128 + 3 * 16 + 5);
        total++;
        if (g_a !== 8'd3) begin
            bad++;
            $display("FAIL scroll_green got %h want 03", g_a);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        goto(36);
        rst = 1'b1;
        step();
        total++;
        if ({de_a, hs_a, vs_a, fs_a, x_a, y_a, r_a, g_a, b_a} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 3'd0, 24'd0}) begin
            bad++;
            $display("FAIL mid_reset got de=%b hs=%b vs=%b fs=%b x=%0d y=%0d rgb=%h", de_a, hs_a,
                     vs_a, fs_a, x_a, y_a, {r_a, g_a, b_a});
        end
        rst = 1'b0;
        step();
        cur = 0;
        total++;
        // mode_a is still 3 but the latched mode was cleared, so bars (white) show.
        if ({x_a, y_a, fs_a, r_a, g_a, b_a} !== {4'd0, 3'd0, 1'b1, 24'hFFFFFF}) begin
            bad++;
            $display("FAIL restart got x=%0d y=%0d fs=%b rgb=%h", x_a, y_a, fs_a, {r_a, g_a, b_a});
        end
        goto(5);
        total++;
        if ({x_a, y_a} !== {4'd5, 3'd0}) begin
            bad++;
            $display("FAIL restart_count got x=%0d y=%0d want 5 0", x_a, y_a);
        end
    endtask

    task automatic test_gradient();
        int pts [3];
        logic [7:0] exp [3];
        pts = '{128 + 16 + 3, 128 + 32, 128 + 48 + 3};
`ifdef VPG_BORDER_EN
        exp = '{8'd3, 8'hFF, 8'hFF};
`else
        exp = '{8'd3, 8'd0, 8'd3};
`endif
        mode_a = 2'd1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            goto(pts[i]);
            total++;
            if ({r_a, g_a, b_a} !== {3{exp[i]}}) begin
                bad++;
                $display("FAIL gradient x=%0d y=%0d got %h want %h", x_a, y_a, {r_a, g_a, b_a},
                         {3{exp[i]}});
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_mode_latch();
        test_scroll();
        test_mid_reset();
        test_gradient();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
